// File: rtl/dtlb_module_pkg.sv
// Shared types and constants for the data TLB: entry layout, PTE flag positions,
// exception codes, FSM states and the permission-check helper.
package dtlb_module_pkg;

  localparam int VPN_W  = 20;
  localparam int PPN_W  = 22;
  localparam int ASID_W = 9;
  localparam int FLAG_W = 8;

  localparam int FLG_V = 0;
  localparam int FLG_R = 1;
  localparam int FLG_W = 2;
  localparam int FLG_X = 3;
  localparam int FLG_U = 4;
  localparam int FLG_G = 5;
  localparam int FLG_A = 6;
  localparam int FLG_D = 7;

  localparam logic [1:0] EXCP_NONE  = 2'd0;
  localparam logic [1:0] EXCP_LOAD  = 2'd1;
  localparam logic [1:0] EXCP_STORE = 2'd2;

  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_M = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic [ASID_W-1:0] asid;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  // Fault when the access kind, accessed/dirty state or privilege level is not allowed.
  function automatic logic perm_fault(input logic [FLAG_W-1:0] flags,
                                      input logic store, input logic [1:0] mode);
    logic f;
    f = (!store && !flags[FLG_R]) || (store && !flags[FLG_W]) || !flags[FLG_A] ||
        (store && !flags[FLG_D]) || (mode == MODE_U && !flags[FLG_U]) ||
        (mode == MODE_S && flags[FLG_U]);
    return f;
  endfunction

  function automatic logic [1:0] fault_code(input logic store);
    return store ? EXCP_STORE : EXCP_LOAD;
  endfunction

endpackage

// File: rtl/dtlb_entry_array.sv
// Fully-associative entry storage: parallel VPN/ASID match, victim selection
// (first free slot, otherwise round-robin) and sfence invalidation.
module dtlb_entry_array
  import dtlb_module_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VPN_W-1:0]  lookup_vpn_i,
  input  logic [ASID_W-1:0] lookup_asid_i,
  output logic              hit_o,
  output logic [PPN_W-1:0]  hit_ppn_o,
  output logic [FLAG_W-1:0] hit_flags_o,
  input  logic              refill_en_i,
  input  entry_t            refill_entry_i,
  input  logic              sfence_en_i,
  input  logic              sfence_all_i,
  input  logic [VPN_W-1:0]  sfence_vpn_i
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  entry_t             entry_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d, match, refill_sel;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, victim, hit_idx;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [VPN_W-1:0] vpn_eff;
      assign match[gi] = valid_q[gi] && (entry_q[gi].vpn == lookup_vpn_i) &&
                         ((entry_q[gi].asid == lookup_asid_i) || entry_q[gi].flags[FLG_G]);
      assign refill_sel[gi] = refill_en_i && (victim == IDX_W'(gi));
      // A same-cycle sfence is compared against the incoming VPN so it wins over the refill.
      assign vpn_eff = refill_sel[gi] ? refill_entry_i.vpn : entry_q[gi].vpn;
      assign valid_d[gi] = (sfence_en_i && (sfence_all_i || vpn_eff == sfence_vpn_i)) ? 1'b0
                         : (valid_q[gi] || refill_sel[gi]);
    end
  endgenerate

  always_comb begin
    hit_idx = '0;
    victim  = rr_ptr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i])    hit_idx = IDX_W'(i);
      if (!valid_q[i]) victim  = IDX_W'(i);
    end
  end

  assign hit_o       = |match;
  assign hit_ppn_o   = entry_q[hit_idx].ppn;
  assign hit_flags_o = entry_q[hit_idx].flags;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (refill_en_i && (&valid_q))
      rr_ptr_d = (rr_ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++)
      if (refill_sel[i]) entry_q[i] <= refill_entry_i;
  end

endmodule

// File: rtl/dtlb_module.sv
// Data TLB top: request FSM (IDLE/WALK/RESP), bare-mode bypass, page-walk handshake
// with the MMU and permission checking of hits and refills.
module dtlb_module
  import dtlb_module_pkg::*;
#(
  parameter int DTLB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_csr_trap_flush,
  input  logic        i_exu_mis_flush,
  input  logic        i_exu_ls_flush,
  input  logic        i_rob_mmu_flush,
  input  logic [31:0] i_rob_mmu_src1,
  input  logic [1:0]  i_csr_rv_mode,
  input  logic [31:0] i_csr_mmu_satp,
  input  logic        i_lsu_dtlb_vld,
  input  logic [31:0] i_lsu_dtlb_vaddr,
  input  logic        i_lsu_dtlb_store,
  output logic        o_dtlb_lsu_rdy,
  output logic        o_dtlb_lsu_resp_vld,
  output logic [33:0] o_dtlb_lsu_paddr,
  output logic [1:0]  o_dtlb_lsu_excp,
  output logic        o_dtlb_mmu_vld,
  output logic [31:0] o_dtlb_mmu_vaddr,
  input  logic        i_mmu_dtlb_vld,
  input  logic [52:0] i_mmu_dtlb_tlb,
  input  logic [33:0] i_mmu_dtlb_paddr,
  input  logic [2:0]  i_mmu_dtlb_excp_code
);

  state_e            state_q, state_d;
  logic [31:0]       vaddr_q, vaddr_d;
  logic              store_q, store_d;
  logic [33:0]       paddr_q, paddr_d;
  logic [1:0]        excp_q, excp_d;
  logic              flush, bare, accept, refill_en, arr_hit;
  logic [PPN_W-1:0]  hit_ppn;
  logic [FLAG_W-1:0] hit_flags, mmu_flags;
  logic [ASID_W-1:0] satp_asid;
  entry_t            refill_entry;
  logic              unused_bits;

  assign flush        = i_csr_trap_flush | i_exu_mis_flush | i_exu_ls_flush;
  assign bare         = !i_csr_mmu_satp[31] || (i_csr_rv_mode == MODE_M);
  assign accept       = i_lsu_dtlb_vld && o_dtlb_lsu_rdy && !flush;
  assign satp_asid    = i_csr_mmu_satp[30:22];
  assign mmu_flags    = i_mmu_dtlb_tlb[52:45];
  assign refill_entry = {vaddr_q[31:12], i_mmu_dtlb_paddr[33:12], satp_asid, mmu_flags};
  assign unused_bits  = ^{i_mmu_dtlb_tlb[44:0], i_mmu_dtlb_paddr[11:0], i_csr_mmu_satp[21:0]};

  dtlb_entry_array #(.ENTRIES(DTLB_ENTRIES)) u_array (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_vpn_i  (i_lsu_dtlb_vaddr[31:12]),
    .lookup_asid_i (satp_asid),
    .hit_o         (arr_hit),
    .hit_ppn_o     (hit_ppn),
    .hit_flags_o   (hit_flags),
    .refill_en_i   (refill_en),
    .refill_entry_i(refill_entry),
    .sfence_en_i   (i_rob_mmu_flush),
    .sfence_all_i  (i_rob_mmu_src1 == 32'h0),
    .sfence_vpn_i  (i_rob_mmu_src1[31:12])
  );

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    store_d   = store_q;
    paddr_d   = paddr_q;
    excp_d    = excp_q;
    refill_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          vaddr_d = i_lsu_dtlb_vaddr;
          store_d = i_lsu_dtlb_store;
          if (bare) begin
            paddr_d = {2'b00, i_lsu_dtlb_vaddr};
            excp_d  = EXCP_NONE;
            state_d = ST_RESP;
          end else if (arr_hit) begin
            if (perm_fault(hit_flags, i_lsu_dtlb_store, i_csr_rv_mode)) begin
              paddr_d = '0;
              excp_d  = fault_code(i_lsu_dtlb_store);
            end else begin
              paddr_d = {hit_ppn, i_lsu_dtlb_vaddr[11:0]};
              excp_d  = EXCP_NONE;
            end
            state_d = ST_RESP;
          end else begin
            state_d = ST_WALK;
          end
        end
      end
      ST_WALK: begin
        // A flush discards the walk result entirely, including the refill.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (i_mmu_dtlb_vld) begin
          state_d = ST_RESP;
          if (i_mmu_dtlb_excp_code != 3'd0) begin
            paddr_d = '0;
            excp_d  = fault_code(store_q);
          end else begin
            refill_en = 1'b1;
            if (perm_fault(mmu_flags, store_q, i_csr_rv_mode)) begin
              paddr_d = '0;
              excp_d  = fault_code(store_q);
            end else begin
              paddr_d = {i_mmu_dtlb_paddr[33:12], vaddr_q[11:0]};
              excp_d  = EXCP_NONE;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      vaddr_q <= '0;
      store_q <= 1'b0;
      paddr_q <= '0;
      excp_q  <= EXCP_NONE;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      store_q <= store_d;
      paddr_q <= paddr_d;
      excp_q  <= excp_d;
    end
  end

  assign o_dtlb_lsu_rdy      = (state_q == ST_IDLE);
  assign o_dtlb_mmu_vld      = (state_q == ST_WALK);
  assign o_dtlb_mmu_vaddr    = vaddr_q;
  assign o_dtlb_lsu_resp_vld = (state_q == ST_RESP) && !flush;
  assign o_dtlb_lsu_paddr    = o_dtlb_lsu_resp_vld ? paddr_q : '0;
  assign o_dtlb_lsu_excp     = o_dtlb_lsu_resp_vld ? excp_q : EXCP_NONE;

endmodule

// File: tb/tb_dtlb_module.sv
// Bench for dtlb_module: vector table of translations plus hand-written flush,
// replacement, sfence and reset sequences; responses checked from a scoreboard queue.
module tb_dtlb_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_csr_trap_flush, i_exu_mis_flush, i_exu_ls_flush;
  logic        i_rob_mmu_flush;
  logic [31:0] i_rob_mmu_src1;
  logic [1:0]  i_csr_rv_mode;
  logic [31:0] i_csr_mmu_satp;
  logic        i_lsu_dtlb_vld;
  logic [31:0] i_lsu_dtlb_vaddr;
  logic        i_lsu_dtlb_store;
  logic        o_dtlb_lsu_rdy, o_dtlb_lsu_resp_vld;
  logic [33:0] o_dtlb_lsu_paddr;
  logic [1:0]  o_dtlb_lsu_excp;
  logic        o_dtlb_mmu_vld;
  logic [31:0] o_dtlb_mmu_vaddr;
  logic        i_mmu_dtlb_vld;
  logic [52:0] i_mmu_dtlb_tlb;
  logic [33:0] i_mmu_dtlb_paddr;
  logic [2:0]  i_mmu_dtlb_excp_code;

  dtlb_module #(.DTLB_ENTRIES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_csr_trap_flush(i_csr_trap_flush), .i_exu_mis_flush(i_exu_mis_flush),
    .i_exu_ls_flush(i_exu_ls_flush), .i_rob_mmu_flush(i_rob_mmu_flush),
    .i_rob_mmu_src1(i_rob_mmu_src1), .i_csr_rv_mode(i_csr_rv_mode),
    .i_csr_mmu_satp(i_csr_mmu_satp), .i_lsu_dtlb_vld(i_lsu_dtlb_vld),
    .i_lsu_dtlb_vaddr(i_lsu_dtlb_vaddr), .i_lsu_dtlb_store(i_lsu_dtlb_store),
    .o_dtlb_lsu_rdy(o_dtlb_lsu_rdy), .o_dtlb_lsu_resp_vld(o_dtlb_lsu_resp_vld),
    .o_dtlb_lsu_paddr(o_dtlb_lsu_paddr), .o_dtlb_lsu_excp(o_dtlb_lsu_excp),
    .o_dtlb_mmu_vld(o_dtlb_mmu_vld), .o_dtlb_mmu_vaddr(o_dtlb_mmu_vaddr),
    .i_mmu_dtlb_vld(i_mmu_dtlb_vld), .i_mmu_dtlb_tlb(i_mmu_dtlb_tlb),
    .i_mmu_dtlb_paddr(i_mmu_dtlb_paddr), .i_mmu_dtlb_excp_code(i_mmu_dtlb_excp_code)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] SA5 = 32'h8140_0000;  // Sv32, ASID 5
  localparam logic [31:0] SA6 = 32'h8180_0000;  // Sv32, ASID 6

  typedef struct {
    logic [31:0] satp;
    logic [1:0]  mode;
    logic [31:0] va;
    logic        st;
    logic        walk;
    int          lat;
    logic [33:0] mpa;
    logic [7:0]  fl;
    logic [2:0]  mex;
    logic [33:0] epa;
    logic [1:0]  eex;
  } vec_t;

  typedef struct packed {
    logic [33:0] pa;
    logic [1:0]  ex;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[14];
  vec_t t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_dtlb_lsu_resp_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got paddr 0x%0h excp %0d want no response",
                 o_dtlb_lsu_paddr, o_dtlb_lsu_excp);
      end else begin
        mon_e = exp_q.pop_front();
        $display("resp paddr=0x%09h excp=%0d (want 0x%09h/%0d)", o_dtlb_lsu_paddr,
                 o_dtlb_lsu_excp, mon_e.pa, mon_e.ex);
        check("resp_paddr", 64'(o_dtlb_lsu_paddr), 64'(mon_e.pa));
        check("resp_excp", 64'(o_dtlb_lsu_excp), 64'(mon_e.ex));
      end
    end
  end

  // Issue one request from IDLE, play the MMU for v.lat cycles if a walk is expected.
  task automatic do_req(input vec_t v, input logic sf);
    int cnt = 0;
    int guard = 0;
    i_csr_mmu_satp = v.satp;
    i_csr_rv_mode  = v.mode;
    while (o_dtlb_lsu_rdy !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_rdy", 64'(o_dtlb_lsu_rdy), 64'd1);
    i_lsu_dtlb_vld   = 1'b1;
    i_lsu_dtlb_vaddr = v.va;
    i_lsu_dtlb_store = v.st;
    exp_q.push_back({v.epa, v.eex});
    @(posedge clk); #1;
    i_lsu_dtlb_vld = 1'b0;
    if (!v.walk) begin
      check("hit_resp_vld", 64'(o_dtlb_lsu_resp_vld), 64'd1);
      check("hit_no_mmu", 64'(o_dtlb_mmu_vld), 64'd0);
    end else begin
      check("walk_mmu_vaddr", 64'(o_dtlb_mmu_vaddr), 64'(v.va));
      guard = 0;
      while (o_dtlb_mmu_vld === 1'b1 && guard < 40) begin
        guard++;
        cnt++;
        if (sf) begin
          i_rob_mmu_flush = 1'b1;
          i_rob_mmu_src1  = {v.va[31:12], 12'h000};
        end
        if (cnt == v.lat) begin
          i_mmu_dtlb_vld       = 1'b1;
          i_mmu_dtlb_paddr     = v.mpa;
          i_mmu_dtlb_tlb       = {v.fl, 45'h0};
          i_mmu_dtlb_excp_code = v.mex;
        end
        @(posedge clk); #1;
        i_mmu_dtlb_vld  = 1'b0;
        i_rob_mmu_flush = 1'b0;
      end
      check("walk_mmu_cycles", 64'(cnt), 64'(v.lat));
      check("miss_resp_vld", 64'(o_dtlb_lsu_resp_vld), 64'd1);
    end
    @(posedge clk); #1;
    check("resp_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic sfence(input logic [31:0] src);
    i_rob_mmu_flush = 1'b1;
    i_rob_mmu_src1  = src;
    @(posedge clk); #1;
    i_rob_mmu_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    {i_csr_trap_flush, i_exu_mis_flush, i_exu_ls_flush, i_rob_mmu_flush} = '0;
    i_rob_mmu_src1 = '0; i_csr_rv_mode = 2'd1; i_csr_mmu_satp = '0;
    i_lsu_dtlb_vld = 1'b0; i_lsu_dtlb_vaddr = '0; i_lsu_dtlb_store = 1'b0;
    i_mmu_dtlb_vld = 1'b0; i_mmu_dtlb_tlb = '0; i_mmu_dtlb_paddr = '0; i_mmu_dtlb_excp_code = '0;

    //           satp mode va           st   walk lat mpa            fl     mex   epa            eex
    vecs[0]  = '{32'h0, 2'd1, 32'h8000_1234, 1'b0, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0_8000_1234, 2'd0};
    vecs[1]  = '{SA5,   2'd1, 32'h4000_0ABC, 1'b0, 1'b1, 3, 34'h1_2345_6000, 8'hCF, 3'd0, 34'h1_2345_6ABC, 2'd0};
    vecs[2]  = '{SA5,   2'd1, 32'h4000_0DEF, 1'b1, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h1_2345_6DEF, 2'd0};
    vecs[3]  = '{SA5,   2'd1, 32'h4000_1000, 1'b1, 1'b1, 1, 34'h0_0777_7000, 8'h4B, 3'd0, 34'h0,          2'd2};
    vecs[4]  = '{SA5,   2'd1, 32'h4000_1234, 1'b0, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0_0777_7234, 2'd0};
    vecs[5]  = '{SA5,   2'd0, 32'h4000_1010, 1'b0, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0,          2'd1};
    vecs[6]  = '{SA5,   2'd1, 32'h5000_0000, 1'b0, 1'b1, 2, 34'h0,          8'h00, 3'd3, 34'h0,          2'd1};
    vecs[7]  = '{SA5,   2'd0, 32'h5000_0000, 1'b0, 1'b1, 2, 34'h0_0123_4000, 8'hDF, 3'd0, 34'h0_0123_4000, 2'd0};
    vecs[8]  = '{SA5,   2'd3, 32'h4000_0ABC, 1'b0, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0_4000_0ABC, 2'd0};
    vecs[9]  = '{SA5,   2'd1, 32'h6000_0000, 1'b1, 1'b1, 1, 34'h0_0555_5000, 8'h87, 3'd0, 34'h0,          2'd2};
    vecs[10] = '{SA5,   2'd1, 32'h5000_0044, 1'b0, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0,          2'd1};
    vecs[11] = '{SA5,   2'd1, 32'h2000_0010, 1'b0, 1'b1, 2, 34'h0_0AAA_A000, 8'hEF, 3'd0, 34'h0_0AAA_A010, 2'd0};
    vecs[12] = '{SA6,   2'd1, 32'h2000_0FFC, 1'b1, 1'b0, 0, 34'h0,          8'h00, 3'd0, 34'h0_0AAA_AFFC, 2'd0};
    vecs[13] = '{SA6,   2'd1, 32'h4000_1000, 1'b0, 1'b1, 1, 34'h0_0BBB_B000, 8'hCF, 3'd0, 34'h0_0BBB_B000, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(o_dtlb_lsu_rdy), 64'd1);
    check("rst_resp_vld", 64'(o_dtlb_lsu_resp_vld), 64'd0);
    check("rst_mmu_vld", 64'(o_dtlb_mmu_vld), 64'd0);
    check("rst_paddr", 64'(o_dtlb_lsu_paddr), 64'd0);
    check("rst_excp", 64'(o_dtlb_lsu_excp), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) do_req(vecs[i], 1'b0);

    // Pipeline flush in the same cycle the walk result arrives.
    i_csr_mmu_satp = SA5; i_csr_rv_mode = 2'd1;
    i_lsu_dtlb_vld = 1'b1; i_lsu_dtlb_vaddr = 32'h7000_0000; i_lsu_dtlb_store = 1'b0;
    @(posedge clk); #1;
    i_lsu_dtlb_vld = 1'b0;
    check("flush_walking", 64'(o_dtlb_mmu_vld), 64'd1);
    i_mmu_dtlb_vld = 1'b1; i_mmu_dtlb_paddr = 34'h0_0999_9000;
    i_mmu_dtlb_tlb = {8'hCF, 45'h0}; i_mmu_dtlb_excp_code = 3'd0; i_exu_ls_flush = 1'b1;
    @(posedge clk); #1;
    i_mmu_dtlb_vld = 1'b0; i_exu_ls_flush = 1'b0;
    check("flush_no_resp", 64'(o_dtlb_lsu_resp_vld), 64'd0);
    check("flush_rdy", 64'(o_dtlb_lsu_rdy), 64'd1);
    t = '{SA5, 2'd1, 32'h7000_0000, 1'b0, 1'b1, 1, 34'h0_0999_9000, 8'hCF, 3'd0, 34'h0_0999_9000, 2'd0};
    do_req(t, 1'b0);

    // Fill the last free slot, then two round-robin replacements (entries 0 and 1).
    t = '{SA5, 2'd1, 32'h1000_0000, 1'b0, 1'b1, 1, 34'h2_0001_0000, 8'hCF, 3'd0, 34'h2_0001_0000, 2'd0};
    do_req(t, 1'b0);
    t.va = 32'h1100_0000; t.mpa = 34'h2_0001_1000; t.epa = 34'h2_0001_1000;
    do_req(t, 1'b0);
    t.va = 32'h1200_0000; t.mpa = 34'h2_0001_2000; t.epa = 34'h2_0001_2000;
    do_req(t, 1'b0);
    t.va = 32'h1100_0000; t.walk = 1'b0; t.epa = 34'h2_0001_1000;
    do_req(t, 1'b0);
    t = '{SA5, 2'd0, 32'h5000_0044, 1'b0, 1'b0, 0, 34'h0, 8'h00, 3'd0, 34'h0_0123_4044, 2'd0};
    do_req(t, 1'b0);
    t = '{SA5, 2'd1, 32'h4000_0ABC, 1'b0, 1'b1, 1, 34'h0_0CCC_C000, 8'hCF, 3'd0, 34'h0_0CCC_CABC, 2'd0};
    do_req(t, 1'b0);
    t = '{SA5, 2'd1, 32'h4000_1000, 1'b0, 1'b1, 1, 34'h0_0DDD_D000, 8'hCF, 3'd0, 34'h0_0DDD_D000, 2'd0};
    do_req(t, 1'b0);

    // Targeted sfence removes only the matching VPN.
    sfence(32'h4000_0000);
    t.walk = 1'b0;
    do_req(t, 1'b0);
    t = '{SA5, 2'd1, 32'h1100_0000, 1'b0, 1'b0, 0, 34'h0, 8'h00, 3'd0, 34'h2_0001_1000, 2'd0};
    do_req(t, 1'b0);
    t = '{SA5, 2'd1, 32'h4000_0ABC, 1'b0, 1'b1, 1, 34'h0_0EEE_E000, 8'hCF, 3'd0, 34'h0_0EEE_EABC, 2'd0};
    do_req(t, 1'b0);

    // Global sfence clears everything.
    sfence(32'h0);
    t = '{SA5, 2'd1, 32'h1100_0000, 1'b0, 1'b1, 1, 34'h2_0001_1000, 8'hCF, 3'd0, 34'h2_0001_1000, 2'd0};
    do_req(t, 1'b0);
    t = '{SA5, 2'd1, 32'h4000_0ABC, 1'b0, 1'b1, 1, 34'h0_0EEE_E000, 8'hCF, 3'd0, 34'h0_0EEE_EABC, 2'd0};
    do_req(t, 1'b0);

    // Sfence during the whole walk, including the refill cycle: response kept, entry dropped.
    t = '{SA5, 2'd1, 32'h3000_0000, 1'b0, 1'b1, 2, 34'h0_0F0F_0000, 8'hCF, 3'd0, 34'h0_0F0F_0000, 2'd0};
    do_req(t, 1'b1);
    t.lat = 1;
    do_req(t, 1'b0);
    t.walk = 1'b0;
    do_req(t, 1'b0);

    // Reset mid-walk, then a late MMU response in IDLE.
    i_lsu_dtlb_vld = 1'b1; i_lsu_dtlb_vaddr = 32'h3800_0000; i_lsu_dtlb_store = 1'b0;
    @(posedge clk); #1;
    i_lsu_dtlb_vld = 1'b0;
    check("rstwalk_walking", 64'(o_dtlb_mmu_vld), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("rstwalk_rdy", 64'(o_dtlb_lsu_rdy), 64'd1);
    check("rstwalk_mmu_vld", 64'(o_dtlb_mmu_vld), 64'd0);
    i_mmu_dtlb_vld = 1'b1; i_mmu_dtlb_paddr = 34'h0_0888_8000;
    i_mmu_dtlb_tlb = {8'hCF, 45'h0}; i_mmu_dtlb_excp_code = 3'd0;
    @(posedge clk); #1;
    i_mmu_dtlb_vld = 1'b0;
    check("late_mmu_no_resp", 64'(o_dtlb_lsu_resp_vld), 64'd0);
    check("late_mmu_rdy", 64'(o_dtlb_lsu_rdy), 64'd1);
    t = '{SA5, 2'd1, 32'h3000_0000, 1'b0, 1'b1, 1, 34'h0_0F0F_0000, 8'hCF, 3'd0, 34'h0_0F0F_0000, 2'd0};
    do_req(t, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
